reg_bank_sequencer: RTL and testbench
=====================================

// Module: reg_bank_sequencer
// PURPOSE
//  Arbitrates two requesters (req0 = control unit, req1 = DMA/loader) for a bank of
//  2**SEL_W Register32bit instances sharing one I/FunSel bus. Drives per-register E
//  (RegE one-hot), FunSel and I. Single-cycle ops pass FunSel straight through.
//  Serial ops load a full 32-bit word as four FunSel=110 byte shifts over an 8-bit path.
// PARAMETERS
//  SEL_W  2  register-select width; NUM_REGS = 2**SEL_W (localparam); RegE width = NUM_REGS
// PORTS
//  Clock        in   1         single clock, rising edge
//  Reset        in   1         asynchronous, active-low reset
//  req0_valid   in   1         requester 0 command valid
//  req0_ready   out  1         requester 0 command accepted (comb.)
//  req0_op      in   3         FunSel code for single-cycle op
//  req0_serial  in   1         1 = 4-beat byte-serial load (op ignored)
//  req0_sel     in   SEL_W     target register index
//  req0_data    in   32        operand / word to load
//  req1_*       -    -         identical set for requester 1
//  RegE         out  NUM_REGS  one-hot register enable (registered)
//  FunSel       out  3         function select to bank (registered)
//  I            out  32        data to bank (registered)
//  busy         out  1         state != IDLE
//  grant_id     out  1         requester owning the current op (registered)
//  done         out  1         1-cycle pulse on final enable cycle of an op
// BEHAVIOUR
//  - Reset (Reset=0, async): state=IDLE, RegE=0, FunSel=000, I=0, grant_id=0, done=0,
//    beat=0, RR pointer=1. Both readies low while Reset=0.
//  - States: IDLE, EXEC, SER.
//  - IDLE: if any valid, pick winner (see arbitration); winner's ready=1 that cycle;
//    loser's ready=0. Accept = valid & ready. Latch op/serial/sel/data; grant_id <= winner.
//    serial=0 -> EXEC; serial=1 -> SER with beat=0. No valid -> stay IDLE.
//  - EXEC (1 cycle): RegE = onehot(sel), FunSel = op, I = data, done=1; -> IDLE.
//  - SER (4 cycles): RegE = onehot(sel), FunSel = 110, I = {24'b0, byte}, where byte is
//    data[31:24], [23:16], [15:8], [7:0] for beat 0..3; done=1 on beat 3; beat 3 -> IDLE.
//    Final register value = data regardless of prior contents.
//  - Outside EXEC/SER: RegE=0, done=0. FunSel/I hold last value (don't-care when E=0).
//  - Latency: accept in cycle N -> E active in N+1 (single) or N+1..N+4 (serial).
//    Next accept no earlier than N+2 (single) / N+5 (serial). ready is low in EXEC/SER.
//  - Fixed arbitration (macro absent): req0 beats req1 when both valid.
//  - A requester holds valid and fields stable until accepted. The block does not
//    check this; it samples fields only on accept.
//  - Reset mid-SER: abort immediately. RegE drops asynchronously. Target keeps its
//    partially shifted value; no repair or replay. Requester must reissue.
//  - Reset mid-EXEC: E drops before the edge; the op does not complete.
// CONFIGURATION
//  RR_ARB_EN defined: round-robin between req0/req1. A 1-bit pointer records the last
//    grant; on a tie, the requester != pointer wins. Pointer updates on every accept.
//    Reset pointer=1, so req0 wins the first tie.
//  RR_ARB_EN undefined: fixed priority req0 > req1; no pointer state.
// TESTING
//  1 Single op: req0 op=010 sel=2 data=DEADBEEF -> ready same cycle; next cycle
//    RegE=0100, FunSel=010, I=DEADBEEF, done=1; R2=DEADBEEF.
//  2 Serial: req1 serial=1 sel=1 data=12345678, R1 preloaded FFFFFFFF -> 4 cycles
//    RegE=0010, FunSel=110, I=12,34,56,78 (low byte); done on 4th; R1=12345678.
//  3 Contention: req0 and req1 valid continuously with single ops -> fixed: all grants
//    to req0. With RR_ARB_EN: grants alternate 0,1,0,1.
//  4 Back-to-back: req0 holds valid, 3 single ops -> accepts every 2nd cycle;
//    busy=1 on the E cycles; ready=0 while busy.
//  5 Reset mid-serial: drop Reset after beat 1 of a serial load of AABBCCDD into R3
//    (R3 was 0) -> RegE=0 immediately, state IDLE, R3=0000AABB, no done pulse.
//  6 Clear op: op=011 sel=0 on R0=5 -> R0=0; decrement op=000 on R0=0 -> R0=FFFFFFFF.

Source files
------------

// File: rtl/reg_bank_sequencer.sv
// reg_bank_sequencer: arbitrates two requesters onto a shared register-bank E/FunSel/I bus.
// Define RR_ARB_EN for round-robin arbitration; otherwise req0 has fixed priority.
module reg_bank_sequencer #(
    parameter int SEL_W = 2
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [2:0]         req0_op,
    input  logic               req0_serial,
    input  logic [SEL_W-1:0]   req0_sel,
    input  logic [31:0]        req0_data,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [2:0]         req1_op,
    input  logic               req1_serial,
    input  logic [SEL_W-1:0]   req1_sel,
    input  logic [31:0]        req1_data,
    output logic [2**SEL_W-1:0] RegE,
    output logic [2:0]         FunSel,
    output logic [31:0]        I,
    output logic               busy,
    output logic               grant_id,
    output logic               done
);
    localparam int NUM_REGS = 2**SEL_W;
    typedef enum logic [1:0] {IDLE, EXEC, SER} state_t;
    state_t state, state_d;
    logic [1:0] beat, beat_d, beat_n;
    logic [SEL_W-1:0] lat_sel, lat_sel_d, w_sel;
    logic [31:0] lat_data, lat_data_d, w_data, i_d;
    logic [NUM_REGS-1:0] rege_d;
    logic [2:0] funsel_d, w_op;
    logic done_d, grant_d, win1, acc, w_serial;
`ifdef RR_ARB_EN
    logic ptr;
    // On a tie the requester that was not granted last wins
    assign win1 = req1_valid & (~req0_valid | ~ptr);
    always_ff @(posedge Clock or negedge Reset)
        if (!Reset) ptr <= 1'b1;
        else if (acc) ptr <= win1;
`else
    assign win1 = req1_valid & ~req0_valid;
`endif
    assign acc = Reset & (state == IDLE) & (req0_valid | req1_valid);
    assign req0_ready = acc & ~win1;
    assign req1_ready = acc & win1;
    assign busy = state != IDLE;
    assign w_op = win1 ? req1_op : req0_op;
    assign w_serial = win1 ? req1_serial : req0_serial;
    assign w_sel = win1 ? req1_sel : req0_sel;
    assign w_data = win1 ? req1_data : req0_data;
    assign beat_n = beat + 2'd1;
    always_comb begin
        state_d = state;
        beat_d = beat;
        lat_sel_d = lat_sel;
        lat_data_d = lat_data;
        rege_d = '0;
        funsel_d = FunSel;
        i_d = I;
        done_d = 1'b0;
        grant_d = grant_id;
        if (acc) begin
            lat_sel_d = w_sel;
            lat_data_d = w_data;
            grant_d = win1;
            beat_d = 2'd0;
            rege_d = NUM_REGS'(1) << w_sel;
            state_d = w_serial ? SER : EXEC;
            funsel_d = w_serial ? 3'b110 : w_op;
            i_d = w_serial ? {24'b0, w_data[31:24]} : w_data;
            done_d = ~w_serial;
        end else if (state == EXEC) begin
            state_d = IDLE;
        end else if (state == SER) begin
            // Outputs are registered, so each edge loads the byte for the following beat
            state_d = (beat == 2'd3) ? IDLE : SER;
            beat_d = beat_n;
            rege_d = (beat == 2'd3) ? '0 : NUM_REGS'(1) << lat_sel;
            i_d = (beat == 2'd3) ? I : {24'b0, lat_data[{~beat_n, 3'b000} +: 8]};
            done_d = beat == 2'd2;
        end
    end
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
            beat <= 2'd0;
            lat_sel <= '0;
            lat_data <= '0;
            RegE <= '0;
            FunSel <= 3'b000;
            I <= '0;
            done <= 1'b0;
            grant_id <= 1'b0;
        end else begin
            state <= state_d;
            beat <= beat_d;
            lat_sel <= lat_sel_d;
            lat_data <= lat_data_d;
            RegE <= rege_d;
            FunSel <= funsel_d;
            I <= i_d;
            done <= done_d;
            grant_id <= grant_d;
        end
    end
endmodule

// File: tb/tb_reg_bank_sequencer.sv
// tb_reg_bank_sequencer: directed bench for reg_bank_sequencer with a behavioural register bank.
module tb_reg_bank_sequencer;
    logic Clock, Reset;
    logic req0_valid, req0_ready, req0_serial, req1_valid, req1_ready, req1_serial;
    logic [2:0] req0_op, req1_op, FunSel;
    logic [1:0] req0_sel, req1_sel;
    logic [31:0] req0_data, req1_data, I;
    logic [3:0] RegE;
    logic busy, grant_id, done;
    logic [31:0] bank [4] = '{default: 32'h0};
    int n_tests = 0;
    int n_fail = 0;

    reg_bank_sequencer #(.SEL_W(2)) dut (
        .Clock(Clock), .Reset(Reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_serial(req0_serial), .req0_sel(req0_sel), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_serial(req1_serial), .req1_sel(req1_sel), .req1_data(req1_data),
        .RegE(RegE), .FunSel(FunSel), .I(I), .busy(busy), .grant_id(grant_id), .done(done)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    function automatic logic [31:0] reg_next(logic [31:0] q, logic [2:0] fs, logic [31:0] d);
        case (fs)
            3'b000: return q - 32'd1;
            3'b001: return q + 32'd1;
            3'b010: return d;
            3'b011: return 32'h0;
            3'b100: return {24'h0, d[7:0]};
            3'b101: return {16'h0, d[15:0]};
            3'b110: return {q[23:0], d[7:0]};
            default: return {{16{d[15]}}, d[15:0]};
        endcase
    endfunction

    // Register32bit model driven by the sequencer's bus
    always @(posedge Clock)
        for (int k = 0; k < 4; k++)
            if (RegE[k]) bank[k] <= reg_next(bank[k], FunSel, I);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    task automatic single(input bit rq, input logic [2:0] op, input logic [1:0] sel, input logic [31:0] d);
        if (rq) begin
            req1_valid = 1; req1_op = op; req1_serial = 0; req1_sel = sel; req1_data = d;
        end else begin
            req0_valid = 1; req0_op = op; req0_serial = 0; req0_sel = sel; req0_data = d;
        end
        #1;
        chk("single_ready", rq ? req1_ready : req0_ready, 1);
        tick();
        req0_valid = 0; req1_valid = 0;
        chk("single_done", done, 1);
        tick();
    endtask

    initial begin
        Reset = 0;
        req0_valid = 1; req0_op = 3'b010; req0_serial = 0; req0_sel = 2; req0_data = 32'hDEADBEEF;
        req1_valid = 1; req1_op = 0; req1_serial = 0; req1_sel = 0; req1_data = 0;
        #3;
        chk("rst_rege", RegE, 0);
        chk("rst_funsel", FunSel, 0);
        chk("rst_i", I, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);
        req1_valid = 0;
        tick(); tick();
        Reset = 1;
        // 1: single load
        #1;
        chk("t1_ready0", req0_ready, 1);
        chk("t1_ready1", req1_ready, 0);
        tick();
        req0_valid = 0;
        chk("t1_rege", RegE, 4'b0100);
        chk("t1_funsel", FunSel, 3'b010);
        chk("t1_i", I, 32'hDEADBEEF);
        chk("t1_done", done, 1);
        chk("t1_busy", busy, 1);
        chk("t1_ready_busy", req0_ready, 0);
        tick();
        chk("t1_r2", bank[2], 32'hDEADBEEF);
        chk("t1_idle_rege", RegE, 0);
        chk("t1_idle_done", done, 0);
        chk("t1_idle_busy", busy, 0);
        // 2: serial load by req1 over preloaded R1
        single(1, 3'b010, 1, 32'hFFFFFFFF);
        chk("t2_pre_r1", bank[1], 32'hFFFFFFFF);
        req1_valid = 1; req1_serial = 1; req1_op = 3'b000; req1_sel = 1; req1_data = 32'h12345678;
        #1;
        chk("t2_ready1", req1_ready, 1);
        tick();
        req1_valid = 0;
        chk("t2_rege", RegE, 4'b0010);
        chk("t2_funsel", FunSel, 3'b110);
        chk("t2_grant", grant_id, 1);
        chk("t2_b0", I, 32'h12);
        chk("t2_done0", done, 0);
        tick();
        chk("t2_b1", I, 32'h34);
        chk("t2_done1", done, 0);
        tick();
        chk("t2_b2", I, 32'h56);
        chk("t2_done2", done, 0);
        tick();
        chk("t2_b3", I, 32'h78);
        chk("t2_done3", done, 1);
        chk("t2_rege3", RegE, 4'b0010);
        tick();
        chk("t2_end_rege", RegE, 0);
        chk("t2_end_busy", busy, 0);
        chk("t2_r1", bank[1], 32'h12345678);
        // 6: clear then decrement
        single(0, 3'b010, 0, 32'h5);
        chk("t6_load", bank[0], 32'h5);
        single(0, 3'b011, 0, 32'h0);
        chk("t6_clear", bank[0], 32'h0);
        single(0, 3'b000, 0, 32'h0);
        chk("t6_dec", bank[0], 32'hFFFFFFFF);
        // 3: contention, both requesters increment continuously
        req0_valid = 1; req0_op = 3'b001; req0_serial = 0; req0_sel = 0;
        req1_valid = 1; req1_op = 3'b001; req1_serial = 0; req1_sel = 3;
        for (int n = 0; n < 4; n++) begin
            #1;
            chk("t3_ready0", req0_ready, 1);
            chk("t3_ready1", req1_ready, 0);
            tick();
            chk("t3_grant", grant_id, 0);
            chk("t3_rege", RegE, 4'b0001);
            chk("t3_busy_ready", {req0_ready, req1_ready}, 0);
            tick();
        end
        req0_valid = 0; req1_valid = 0;
        tick();
        chk("t3_r0", bank[0], 32'h3);
        chk("t3_r3", bank[3], 32'h0);
        // 4: back-to-back single ops from req0
        req0_valid = 1; req0_op = 3'b010; req0_sel = 2;
        for (int n = 1; n <= 3; n++) begin
            req0_data = n;
            #1;
            chk("t4_ready", req0_ready, 1);
            tick();
            chk("t4_busy", busy, 1);
            chk("t4_ready_busy", req0_ready, 0);
            chk("t4_done", done, 1);
            chk("t4_i", I, n);
            tick();
        end
        req0_valid = 0;
        chk("t4_r2", bank[2], 32'h3);
        // 5: reset during serial load into R3
        req0_valid = 1; req0_serial = 1; req0_sel = 3; req0_data = 32'hAABBCCDD;
        #1;
        chk("t5_ready", req0_ready, 1);
        tick();
        chk("t5_b0", I, 32'hAA);
        tick();
        chk("t5_b1", I, 32'hBB);
        chk("t5_done1", done, 0);
        tick();
        Reset = 0;
        #1;
        chk("t5_rege_drop", RegE, 0);
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        chk("t5_ready_rst", req0_ready, 0);
        tick(); tick();
        chk("t5_r3", bank[3], 32'h0000AABB);
        chk("t5_done_later", done, 0);
        req0_valid = 0;
        Reset = 1;
        tick();
        chk("t5_idle", busy, 0);
        chk("t5_r3_final", bank[3], 32'h0000AABB);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
